// File: rtl/axis_histogram_pkg.sv
// Shared types and helpers for the multi-channel AXI-Stream histogrammer.
// Holds the controller state encoding and the bin clamp / address helpers.
package axis_histogram_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN
    } state_t;

    function automatic logic [31:0] clamp_bin(
        input logic [31:0] v,
        input int unsigned bw
    );
        logic [31:0] lim;
        lim = (32'd1 << bw) - 32'd1;
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [31:0] make_addr(
        input logic [31:0] chan,
        input logic [31:0] bin,
        input int unsigned bw
    );
        return (chan << bw) | bin;
    endfunction

endpackage

// File: rtl/axis_histogram_multi_if.sv
// AXI-Stream sample bus: unsigned sample, channel id in tuser.
// Master drives data/valid, slave answers with ready.
interface axis_histogram_multi_if #(
    parameter int DATA_W = 16,
    parameter int USER_W = 2
) ();

    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tvalid;
    logic              tready;

    modport master (
        output tdata, tuser, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tuser, tvalid,
        output tready
    );

endinterface

// File: rtl/axis_histogram_bin.sv
// Maps a sample to its memory address: shift, clamp to the last bin,
// then prepend the channel id.
module axis_histogram_bin
    import axis_histogram_pkg::*;
#(
    parameter int DW = 16,
    parameter int CW = 2,
    parameter int BW = 12
) (
    input  logic [DW-1:0]    tdata,
    input  logic [CW-1:0]    chan,
    input  logic [4:0]       shift,
    output logic [CW+BW-1:0] addr
);

    logic [31:0] shifted;
    logic [31:0] bin;

    // Purely combinational bin/address computation
    always_comb begin
        shifted = 32'(tdata) >> shift;
        bin     = clamp_bin(shifted, BW);
        addr    = (CW+BW)'(make_addr(32'(chan), bin, BW));
    end

endmodule

// File: rtl/axis_histogram_multi.sv
// Multi-channel histogram: clear sweep, 3-stage read-modify-write
// into an external dual-port BRAM with forwarding and saturation.
module axis_histogram_multi
    import axis_histogram_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 16,
    parameter int CHAN_WIDTH       = 2,
    parameter int BIN_WIDTH        = 12,
    parameter int BRAM_DATA_WIDTH  = 32,
    localparam int BRAM_ADDR_WIDTH = CHAN_WIDTH + BIN_WIDTH
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [4:0]                 cfg_shift,
    input  logic                       cfg_clear,
    output logic                       sts_busy,
    axis_histogram_multi_if.slave      s_axis,
    output logic                       bram_porta_clk,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_porta_addr,
    output logic [BRAM_DATA_WIDTH-1:0] bram_porta_wrdata,
    output logic                       bram_porta_we,
    output logic                       bram_portb_clk,
    output logic [BRAM_ADDR_WIDTH-1:0] bram_portb_addr,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_portb_rddata
);

    localparam int AW = BRAM_ADDR_WIDTH;
    localparam int DW = BRAM_DATA_WIDTH;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_addr_q, clr_addr_d;
    logic            drain_q, drain_d;
    logic            init_q, init_d;
    logic            s1_valid_q, s1_valid_d;
    logic [AW-1:0]   s1_addr_q, s1_addr_d;
    logic            s2_valid_q, s2_valid_d;
    logic [AW-1:0]   s2_addr_q, s2_addr_d;
    logic            lst_valid_q, lst_valid_d;
    logic [AW-1:0]   lst_addr_q, lst_addr_d;
    logic [DW-1:0]   lst_data_q, lst_data_d;

    logic [AW-1:0]   bin_addr;
    logic [DW-1:0]   operand;
    logic            sat;
    logic            rdy;
    logic            busy;

    axis_histogram_bin #(
        .DW (AXIS_TDATA_WIDTH),
        .CW (CHAN_WIDTH),
        .BW (BIN_WIDTH)
    ) u_bin (
        .tdata (s_axis.tdata),
        .chan  (s_axis.tuser),
        .shift (cfg_shift),
        .addr  (bin_addr)
    );

    assign bram_porta_clk  = aclk;
    assign bram_portb_clk  = aclk;
    assign bram_portb_addr = s1_addr_q;
    assign s_axis.tready   = rdy;
    assign sts_busy        = busy;

    // Controller, write-port mux and pipeline next-state
    always_comb begin
        operand = (lst_valid_q && lst_addr_q == s2_addr_q)
                ? lst_data_q : bram_portb_rddata;
        sat     = &operand;

        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        drain_d    = drain_q;
        init_d     = 1'b1;
        rdy        = 1'b0;
        busy       = 1'b1;

        bram_porta_addr   = s2_addr_q;
        bram_porta_wrdata = operand + DW'(1);
        bram_porta_we     = s2_valid_q && !sat;

        unique case (state_q)
            ST_CLEAR: begin
                bram_porta_addr   = clr_addr_q;
                bram_porta_wrdata = '0;
                bram_porta_we     = init_q;
                if (init_q) begin
                    clr_addr_d = clr_addr_q + AW'(1);
                    if (&clr_addr_q) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                rdy  = 1'b1;
                busy = 1'b0;
                if (cfg_clear) begin
                    state_d = ST_DRAIN;
                    drain_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        s1_valid_d  = s_axis.tvalid && rdy;
        s1_addr_d   = s1_valid_d ? bin_addr : s1_addr_q;
        s2_valid_d  = s1_valid_q;
        s2_addr_d   = s1_addr_q;
        lst_valid_d = s2_valid_q;
        lst_addr_d  = s2_addr_q;
        lst_data_d  = sat ? operand : operand + DW'(1);
    end

    // State and pipeline registers with synchronous reset
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= '0;
            drain_q     <= 1'b0;
            init_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_addr_q   <= '0;
            lst_valid_q <= 1'b0;
            lst_addr_q  <= '0;
            lst_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            drain_q     <= drain_d;
            init_q      <= init_d;
            s1_valid_q  <= s1_valid_d;
            s1_addr_q   <= s1_addr_d;
            s2_valid_q  <= s2_valid_d;
            s2_addr_q   <= s2_addr_d;
            lst_valid_q <= lst_valid_d;
            lst_addr_q  <= lst_addr_d;
            lst_data_q  <= lst_data_d;
        end
    end

endmodule

// File: tb/tb_axis_histogram_multi.sv
// Bench for axis_histogram_multi: BRAM model plus a count-per-address
// reference histogram, directed and random stimulus.
module tb_axis_histogram_multi;

    localparam int N = 16384;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [4:0]  cfg_shift = '0;
    logic        cfg_clear = 1'b0;
    logic        busy;
    logic        porta_clk, portb_clk, porta_we;
    logic [13:0] porta_addr, portb_addr;
    logic [31:0] porta_wrdata;
    logic [31:0] portb_rddata;

    logic        pre_we = 1'b0;
    logic [13:0] pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [31:0] mem [N];

    longint unsigned exp_cnt [N];
    int n_assert = 0;
    int n_fail = 0;

    axis_histogram_multi_if #(.DATA_W(16), .USER_W(2)) s_axis ();

    axis_histogram_multi dut (
        .aclk              (clk),
        .areset            (areset),
        .cfg_shift         (cfg_shift),
        .cfg_clear         (cfg_clear),
        .sts_busy          (busy),
        .s_axis            (s_axis),
        .bram_porta_clk    (porta_clk),
        .bram_porta_addr   (porta_addr),
        .bram_porta_wrdata (porta_wrdata),
        .bram_porta_we     (porta_we),
        .bram_portb_clk    (portb_clk),
        .bram_portb_addr   (portb_addr),
        .bram_portb_rddata (portb_rddata)
    );

    always #5 clk = ~clk;

    // Read-first BRAM with 1-cycle read latency and a preload port
    always @(posedge clk) begin
        if (porta_we) mem[porta_addr] <= porta_wrdata;
        if (pre_we) mem[pre_addr] <= pre_data;
        portb_rddata <= mem[portb_addr];
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int bin_addr(input int d, input int c, input int s);
        int unsigned b;
        b = int'(d) >> s;
        if (b > 4095) b = 4095;
        return c * 4096 + int'(b);
    endfunction

    task automatic clear_model();
        for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    endtask

    task automatic model_hit(input int a);
        if (exp_cnt[a] < 64'hFFFF_FFFF) exp_cnt[a] = exp_cnt[a] + 1;
    endtask

    task automatic drive(input bit v, input int d, input int c, input int s);
        s_axis.tvalid = v;
        s_axis.tdata  = 16'(d);
        s_axis.tuser  = 2'(c);
        cfg_shift     = 5'(s);
    endtask

    task automatic push(input bit v, input int d, input int c, input int s);
        drive(v, d, c, s);
        if (v && s_axis.tready === 1'b1) model_hit(bin_addr(d, c, s));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_mem(input string tag);
        int bad = 0;
        for (int i = 0; i < N; i++)
            if (mem[i] !== 32'(exp_cnt[i])) bad++;
        chk(tag, 64'(bad), 64'd0);
    endtask

    task automatic do_reset(input int cyc);
        areset = 1'b1;
        cfg_clear = 1'b0;
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("rst_we", 64'(porta_we), 64'd0);
        chk("rst_tready", 64'(s_axis.tready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        repeat (cyc - 1) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
    endtask

    task automatic sweep(input bit poke);
        int bad = 0;
        for (int i = 0; i < N; i++) begin
            if (porta_we !== 1'b1 || porta_addr !== 14'(i) ||
                porta_wrdata !== 32'd0 || busy !== 1'b1 ||
                s_axis.tready !== 1'b0) bad++;
            cfg_clear = poke && (i == 200);
            @(negedge clk);
        end
        cfg_clear = 1'b0;
        chk("sweep_writes", 64'(bad), 64'd0);
        chk("sweep_end_we", 64'(porta_we), 64'd0);
        chk("run_tready", 64'(s_axis.tready), 64'd1);
        chk("run_busy", 64'(busy), 64'd0);
        clear_model();
    endtask

    initial begin
        int a, b, sa;
        bit ew;
        drive(0, 0, 0, 0);
        clear_model();

        do_reset(3);
        repeat (100) @(negedge clk);
        chk("mid_sweep_addr", 64'(porta_addr), 64'd100);
        chk("bram_clk_lo", 64'({porta_clk, portb_clk}), 64'd0);
        @(posedge clk);
        #1;
        chk("bram_clk_hi", 64'({porta_clk, portb_clk}), 64'd3);
        @(negedge clk);
        do_reset(2);
        sweep(1);
        check_mem("after_reset_zero");

        for (int i = 0; i < 5; i++) push(1, 7, 1, 0);
        idle(4);
        chk("bin_1_7", 64'(mem[4096 + 7]), 64'd5);
        check_mem("b2b_hist");

        a = bin_addr(int'($urandom_range(0, 4095)), 0, 0);
        b = bin_addr(int'($urandom_range(0, 4095)), 3, 0);
        for (int i = 0; i < 100; i++) begin
            if (i % 2 == 0) push(1, a, 0, 0);
            else push(1, b - 3 * 4096, 3, 0);
        end
        idle(4);
        chk("alt_a", 64'(mem[a]), 64'd50);
        chk("alt_b", 64'(mem[b]), 64'd50);
        check_mem("alt_hist");

        push(1, 'hFFFF, 2, 0);
        idle(1);
        chk("clamp_addr", 64'(porta_addr), 64'h2FFF);
        chk("clamp_we", 64'(porta_we), 64'd1);
        idle(2);
        push(1, 'h0100, 0, 4);
        idle(1);
        chk("shift_addr", 64'(porta_addr), 64'd16);
        idle(3);
        check_mem("clamp_hist");

        sa = bin_addr(1000, 1, 0);
        pre_we = 1'b1;
        pre_addr = 14'(sa);
        pre_data = 32'hFFFF_FFFE;
        @(negedge clk);
        pre_we = 1'b0;
        exp_cnt[sa] = 64'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) begin
            ew = exp_cnt[sa] != 64'hFFFF_FFFF;
            push(1, 1000, 1, 0);
            idle(1);
            chk($sformatf("sat_we_%0d", k), 64'(porta_we), 64'(ew));
            idle(2);
        end
        chk("sat_final", 64'(mem[sa]), 64'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) push(1, 1000, 1, 0);
        idle(4);
        check_mem("sat_hist");

        for (int i = 0; i < 600; i++) begin
            int s, d;
            s = int'($urandom_range(0, 5));
            d = ($urandom_range(0, 9) == 0) ? int'($urandom & 'hFFFF)
                                            : int'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) s = 0;
            push($urandom_range(0, 3) != 0, d, int'($urandom_range(0, 3)), s);
        end
        idle(4);
        check_mem("random_hist");

        for (int i = 0; i < 15; i++) push(1, 200 + i, 2, 0);
        cfg_clear = 1'b1;
        push(1, 215, 2, 0);
        cfg_clear = 1'b0;
        drive(1, 216, 2, 0);
        chk("drain1_tready", 64'(s_axis.tready), 64'd0);
        chk("drain1_busy", 64'(busy), 64'd1);
        chk("drain1_we", 64'(porta_we), 64'd1);
        chk("drain1_addr", 64'(porta_addr), 64'(bin_addr(214, 2, 0)));
        @(negedge clk);
        chk("drain2_tready", 64'(s_axis.tready), 64'd0);
        chk("drain2_we", 64'(porta_we), 64'd1);
        chk("drain2_addr", 64'(porta_addr), 64'(bin_addr(215, 2, 0)));
        @(negedge clk);
        sweep(0);
        drive(0, 0, 0, 0);
        check_mem("after_clear_zero");

        for (int i = 0; i < 8; i++) push(1, i, 3, 0);
        do_reset(2);
        sweep(0);
        check_mem("after_midpipe_reset");
        for (int i = 0; i < 6; i++) push(1, 5 * (i % 2), 0, 0);
        idle(4);
        check_mem("post_reset_hist");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
